// File: rtl/mrr_tx_frame_encoder.sv
// MRR transmit frame encoder: serializes header, optional chip-id and payload
// into an on-off-keyed IQ sample stream, with a recharge gap between frames.
module mrr_tx_frame_encoder #(
    parameter int unsigned           HEADER_LEN     = 16,
    parameter logic [HEADER_LEN-1:0] HEADER_PATTERN = 16'hE5B2,
    parameter int unsigned           CHIPID_WIDTH   = 8,
    parameter int unsigned           SYM_LEN_WIDTH  = 16,
    parameter logic [15:0]           OOK_AMPL       = 16'h4000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              i_tdata,
    input  logic                     i_tvalid,
    output logic                     i_tready,
    input  logic                     tx_disable,
    input  logic                     tx_chipid,
    input  logic [CHIPID_WIDTH-1:0]  chip_id,
    input  logic [7:0]               num_payload_bits,
    input  logic [SYM_LEN_WIDTH-1:0] wait_step,
    input  logic [14:0]              recharge_len,
    output logic [31:0]              o_tdata,
    output logic                     o_tvalid,
    input  logic                     o_tready,
    output logic                     o_tlast,
    output logic                     tx_en,
    output logic                     busy
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready
    // are both high; valid/data/last are held stable until that transfer.

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_CHIPID,
        S_PAYLOAD,
        S_RECHARGE
    } state_t;

    localparam logic [5:0]               HDR_LAST  = 6'(HEADER_LEN - 1);
    localparam logic [5:0]               CHIP_LAST = 6'(CHIPID_WIDTH - 1);
    localparam logic [SYM_LEN_WIDTH-1:0] ONE_SAMP  = {{(SYM_LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                    state_q, state_d;
    logic [SYM_LEN_WIDTH-1:0]  samp_q, samp_d;
    logic [5:0]                bit_q, bit_d;
    logic [14:0]               rech_q, rech_d;
    logic [HEADER_LEN-1:0]     hdr_sr_q, hdr_sr_d;
    logic [CHIPID_WIDTH-1:0]   chip_sr_q, chip_sr_d;
    logic [31:0]               data_sr_q, data_sr_d;
    logic                      chip_en_q, chip_en_d;
    logic [5:0]                len_q, len_d;
    logic [SYM_LEN_WIDTH-1:0]  wait_q, wait_d;

    logic                      i_tready_q, o_tvalid_q, o_tlast_q, tx_en_q, busy_q;
    logic [31:0]               o_tdata_q;

    logic                      accept_in, accept_out, field_last;
    state_t                    after_hdr, after_chip;
    logic                      active_d, cur_bit_d, final_bit_d, tlast_d;

    assign accept_in  = i_tvalid && i_tready_q;
    assign accept_out = o_tvalid_q && o_tready;

    always_comb begin
        state_d    = state_q;
        samp_d     = samp_q;
        bit_d      = bit_q;
        rech_d     = rech_q;
        hdr_sr_d   = hdr_sr_q;
        chip_sr_d  = chip_sr_q;
        data_sr_d  = data_sr_q;
        chip_en_d  = chip_en_q;
        len_d      = len_q;
        wait_d     = wait_q;
        after_chip = (len_q != 6'd0) ? S_PAYLOAD : S_RECHARGE;
        after_hdr  = chip_en_q ? S_CHIPID : after_chip;
        field_last = 1'b0;
        unique case (state_q)
            S_HEADER:  field_last = (bit_q == HDR_LAST);
            S_CHIPID:  field_last = (bit_q == CHIP_LAST);
            S_PAYLOAD: field_last = (bit_q == len_q - 6'd1);
            default:   field_last = 1'b0;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (accept_in) begin
                    state_d   = S_HEADER;
                    samp_d    = '0;
                    bit_d     = '0;
                    hdr_sr_d  = HEADER_PATTERN;
                    chip_sr_d = chip_id;
                    data_sr_d = i_tdata;
                    chip_en_d = tx_chipid;
                    len_d     = (num_payload_bits > 8'd32) ? 6'd32 : num_payload_bits[5:0];
                    wait_d    = (wait_step == '0) ? ONE_SAMP : wait_step;
                end
            end
            S_HEADER, S_CHIPID, S_PAYLOAD: begin
                if (accept_out) begin
                    if (samp_q == wait_q - ONE_SAMP) begin
                        samp_d = '0;
                        if (field_last) begin
                            // Fields with nothing to send are skipped in this same step.
                            bit_d = '0;
                            if (state_q == S_HEADER) begin
                                state_d = after_hdr;
                            end else if (state_q == S_CHIPID) begin
                                state_d = after_chip;
                            end else begin
                                state_d = S_RECHARGE;
                            end
                            if (state_d == S_RECHARGE) begin
                                rech_d = recharge_len;
                            end
                        end else begin
                            bit_d = bit_q + 6'd1;
                            if (state_q == S_HEADER) begin
                                hdr_sr_d = hdr_sr_q << 1;
                            end else if (state_q == S_CHIPID) begin
                                chip_sr_d = chip_sr_q << 1;
                            end else begin
                                data_sr_d = data_sr_q << 1;
                            end
                        end
                    end else begin
                        samp_d = samp_q + ONE_SAMP;
                    end
                end
            end
            S_RECHARGE: begin
                if (rech_q <= 15'd1) begin
                    state_d = S_IDLE;
                end else begin
                    rech_d = rech_q - 15'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        active_d    = (state_d == S_HEADER) || (state_d == S_CHIPID) || (state_d == S_PAYLOAD);
        cur_bit_d   = 1'b0;
        final_bit_d = 1'b0;
        unique case (state_d)
            S_HEADER: begin
                cur_bit_d   = hdr_sr_d[HEADER_LEN-1];
                final_bit_d = !chip_en_d && (len_d == 6'd0) && (bit_d == HDR_LAST);
            end
            S_CHIPID: begin
                cur_bit_d   = chip_sr_d[CHIPID_WIDTH-1];
                final_bit_d = (len_d == 6'd0) && (bit_d == CHIP_LAST);
            end
            S_PAYLOAD: begin
                cur_bit_d   = data_sr_d[31];
                final_bit_d = (bit_d == len_d - 6'd1);
            end
            default: begin
                cur_bit_d   = 1'b0;
                final_bit_d = 1'b0;
            end
        endcase
        tlast_d = final_bit_d && (samp_d == wait_d - ONE_SAMP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            samp_q     <= '0;
            bit_q      <= '0;
            rech_q     <= '0;
            hdr_sr_q   <= '0;
            chip_sr_q  <= '0;
            data_sr_q  <= '0;
            chip_en_q  <= 1'b0;
            len_q      <= '0;
            wait_q     <= '0;
            i_tready_q <= 1'b0;
            o_tvalid_q <= 1'b0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
            tx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            rech_q     <= rech_d;
            hdr_sr_q   <= hdr_sr_d;
            chip_sr_q  <= chip_sr_d;
            data_sr_q  <= data_sr_d;
            chip_en_q  <= chip_en_d;
            len_q      <= len_d;
            wait_q     <= wait_d;
            i_tready_q <= (state_d == S_IDLE) && !tx_disable;
            o_tvalid_q <= active_d;
            o_tdata_q  <= (active_d && cur_bit_d) ? {OOK_AMPL, 16'h0000} : 32'h0;
            o_tlast_q  <= tlast_d;
            tx_en_q    <= active_d && cur_bit_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end

    assign i_tready = i_tready_q;
    assign o_tvalid = o_tvalid_q;
    assign o_tdata  = o_tdata_q;
    assign o_tlast  = o_tlast_q;
    assign tx_en    = tx_en_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mrr_tx_frame_encoder.sv
// Bench for mrr_tx_frame_encoder: frame model feeds an expected-sample queue that
// a monitor pops on every accepted output sample.
module tb_mrr_tx_frame_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_tdata;
    logic        i_tvalid;
    logic        i_tready;
    logic        tx_disable;
    logic        tx_chipid;
    logic [7:0]  chip_id;
    logic [7:0]  num_payload_bits;
    logic [15:0] wait_step;
    logic [14:0] recharge_len;
    logic [31:0] o_tdata;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic        o_tlast;
    logic        tx_en;
    logic        busy;

    logic [33:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_total = 0;
    int          tlast_total = 0;
    int          last_tlast_cyc = -1;
    int          stall_cnt = 0;
    bit          bp_en = 1'b0;

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    mrr_tx_frame_encoder dut (
        .clk              (clk),
        .rst              (rst),
        .i_tdata          (i_tdata),
        .i_tvalid         (i_tvalid),
        .i_tready         (i_tready),
        .tx_disable       (tx_disable),
        .tx_chipid        (tx_chipid),
        .chip_id          (chip_id),
        .num_payload_bits (num_payload_bits),
        .wait_step        (wait_step),
        .recharge_len     (recharge_len),
        .o_tdata          (o_tdata),
        .o_tvalid         (o_tvalid),
        .o_tready         (o_tready),
        .o_tlast          (o_tlast),
        .tx_en            (tx_en),
        .busy             (busy)
    );

    // Clock and cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        o_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard monitor: sampled just after the falling edge, i.e. exactly what
    // the next rising edge will see.
    always @(negedge clk) begin
        logic [33:0] e;
        #1;
        if (rst === 1'b1) begin
            checks++;
            if (i_tready === 1'b1 && busy !== 1'b0) begin
                errors++;
                $display("FAIL ready_while_busy: i_tready=%b busy=%b required busy=0", i_tready, busy);
            end
            if (prev_stall) begin
                stall_cnt++;
                checks++;
                if (o_tvalid !== 1'b1 || o_tdata !== prev_data || o_tlast !== prev_last) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                             o_tvalid, o_tdata, o_tlast, prev_data, prev_last);
                end
            end
            if (o_tvalid === 1'b1 && o_tready === 1'b1) begin
                acc_total++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sample_unexpected: data=%h last=%b with nothing expected", o_tdata, o_tlast);
                end else begin
                    e = exp_q.pop_front();
                    if ({tx_en, o_tlast, o_tdata} !== e) begin
                        errors++;
                        $display("FAIL sample_%0d: tx_en=%b last=%b data=%h required tx_en=%b last=%b data=%h",
                                 acc_total, tx_en, o_tlast, o_tdata, e[33], e[32], e[31:0]);
                    end
                end
                if (o_tlast === 1'b1) begin
                    tlast_total++;
                    last_tlast_cyc = cyc;
                end
            end
            prev_stall = (o_tvalid === 1'b1) && (o_tready === 1'b0);
            prev_data  = o_tdata;
            prev_last  = o_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Expected-sample model built from the current bench settings.
    task automatic push_frame(input logic [31:0] d);
        logic        fb[$];
        logic [15:0] hdr;
        int          len;
        int          w;
        hdr = 16'hE5B2;
        len = (int'(num_payload_bits) > 32) ? 32 : int'(num_payload_bits);
        w   = (wait_step == 16'd0) ? 1 : int'(wait_step);
        for (int i = 15; i >= 0; i--) fb.push_back(hdr[i]);
        if (tx_chipid) begin
            for (int i = 7; i >= 0; i--) fb.push_back(chip_id[i]);
        end
        for (int i = 0; i < len; i++) fb.push_back(d[31-i]);
        for (int b = 0; b < fb.size(); b++) begin
            for (int s = 0; s < w; s++) begin
                exp_q.push_back({fb[b], (b == fb.size() - 1) && (s == w - 1),
                                 fb[b] ? 32'h4000_0000 : 32'h0});
            end
        end
    endtask

    task automatic send_word(input logic [31:0] d, output int hs_cyc);
        bit hs;
        hs     = 1'b0;
        hs_cyc = -1;
        @(negedge clk);
        i_tdata  = d;
        i_tvalid = 1'b1;
        push_frame(d);
        for (int n = 0; n < 400; n++) begin
            hs     = i_tready;
            hs_cyc = cyc;
            @(negedge clk);
            if (hs) break;
        end
        i_tvalid = 1'b0;
        checks++;
        if (!hs) begin
            errors++;
            $display("FAIL handshake_timeout: word %h never accepted, i_tready=%b required 1", d, i_tready);
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            #2;
            if (exp_q.size() == 0 && busy === 1'b0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: %0d samples outstanding busy=%b, required 0 and 0", name, exp_q.size(), busy);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++;
        if ({i_tready, o_tvalid, o_tlast, tx_en, busy} !== 5'b0 || o_tdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b last=%b txen=%b busy=%b data=%h required all 0",
                     i_tready, o_tvalid, o_tlast, tx_en, busy, o_tdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (i_tready !== 1'b1 || busy !== 1'b0 || o_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b busy=%b vld=%b required 1 0 0", i_tready, busy, o_tvalid);
        end
    endtask

    task automatic test_basic();
        int h, n0, t0;
        tx_chipid = 1'b0; num_payload_bits = 8'd8; wait_step = 16'd2; recharge_len = 15'd3;
        n0 = acc_total; t0 = tlast_total;
        send_word(32'hA500_0000, h);
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== 32'h4000_0000) begin
            errors++;
            $display("FAIL basic_latency: vld=%b data=%h required 1 40000000", o_tvalid, o_tdata);
        end
        wait_idle(300, "basic");
        checks++;
        if (acc_total - n0 != 48 || tlast_total - t0 != 1) begin
            errors++;
            $display("FAIL basic_length: samples=%0d tlasts=%0d required 48 1", acc_total - n0, tlast_total - t0);
        end
    endtask

    task automatic test_chipid_clamp();
        int h, n0, t0;
        tx_chipid = 1'b1; chip_id = 8'h3C; num_payload_bits = 8'd40; wait_step = 16'd0; recharge_len = 15'd0;
        n0 = acc_total; t0 = tlast_total;
        send_word(32'h8000_0001, h);
        checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== 32'h4000_0000) begin
            errors++;
            $display("FAIL chipid_latency: vld=%b data=%h required 1 40000000", o_tvalid, o_tdata);
        end
        wait_idle(300, "chipid");
        checks++;
        if (acc_total - n0 != 56 || tlast_total - t0 != 1) begin
            errors++;
            $display("FAIL chipid_length: samples=%0d tlasts=%0d required 56 1", acc_total - n0, tlast_total - t0);
        end
    endtask

    task automatic test_backpressure();
        int h, n0, s0;
        tx_chipid = 1'b0; num_payload_bits = 8'd8; wait_step = 16'd2; recharge_len = 15'd3;
        n0 = acc_total; s0 = stall_cnt;
        bp_en = 1'b1;
        send_word(32'hA500_0000, h);
        wait_idle(600, "backpressure");
        bp_en = 1'b0;
        checks++;
        if (acc_total - n0 != 48) begin
            errors++;
            $display("FAIL bp_length: samples=%0d required 48", acc_total - n0);
        end
        checks++;
        if (stall_cnt - s0 <= 0) begin
            errors++;
            $display("FAIL bp_stalls: stalled cycles=%0d required >0", stall_cnt - s0);
        end
    endtask

    task automatic test_back_to_back();
        int h1, h2, n0, t0;
        tx_chipid = 1'b0; num_payload_bits = 8'd4; wait_step = 16'd1; recharge_len = 15'd5;
        n0 = acc_total; t0 = tlast_total;
        send_word(32'hC000_0000, h1);
        send_word(32'h3000_0000, h2);
        checks++;
        if (o_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_start: vld=%b required 1", o_tvalid);
        end
        checks++;
        if (h2 - last_tlast_cyc != 6 || h2 - h1 != 26) begin
            errors++;
            $display("FAIL b2b_gap: tlast->accept=%0d accept->accept=%0d required 6 26",
                     h2 - last_tlast_cyc, h2 - h1);
        end
        wait_idle(300, "b2b");
        checks++;
        if (acc_total - n0 != 40 || tlast_total - t0 != 2) begin
            errors++;
            $display("FAIL b2b_length: samples=%0d tlasts=%0d required 40 2", acc_total - n0, tlast_total - t0);
        end
    endtask

    task automatic test_tx_disable();
        int h, n0;
        tx_chipid = 1'b0; num_payload_bits = 8'd8; wait_step = 16'd1; recharge_len = 15'd2;
        n0 = acc_total;
        send_word(32'h5A00_0000, h);
        repeat (5) @(negedge clk);
        tx_disable = 1'b1;
        wait_idle(300, "disable");
        checks++;
        if (acc_total - n0 != 24) begin
            errors++;
            $display("FAIL disable_frame: samples=%0d required 24", acc_total - n0);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (i_tready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL disable_block: rdy=%b busy=%b required 0 0", i_tready, busy);
        end
        tx_disable = 1'b0;
        @(negedge clk);
        checks++;
        if (i_tready !== 1'b1) begin
            errors++;
            $display("FAIL disable_release: rdy=%b required 1", i_tready);
        end
        n0 = acc_total;
        send_word(32'h0F00_0000, h);
        wait_idle(300, "disable_next");
        checks++;
        if (acc_total - n0 != 24) begin
            errors++;
            $display("FAIL disable_next_frame: samples=%0d required 24", acc_total - n0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int h, n0, t0;
        bit reached;
        reached = 1'b0;
        tx_chipid = 1'b0; num_payload_bits = 8'd32; wait_step = 16'd2; recharge_len = 15'd3;
        n0 = acc_total;
        send_word(32'h1234_5678, h);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #2;
            if (acc_total - n0 >= 40) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached || o_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reach: samples=%0d vld=%b required >=40 1", acc_total - n0, o_tvalid);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({i_tready, o_tvalid, o_tlast, tx_en, busy} !== 5'b0 || o_tdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset_async: rdy=%b vld=%b last=%b txen=%b busy=%b data=%h required all 0",
                     i_tready, o_tvalid, o_tlast, tx_en, busy, o_tdata);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (i_tready !== 1'b1 || busy !== 1'b0 || o_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: rdy=%b busy=%b vld=%b required 1 0 0", i_tready, busy, o_tvalid);
        end
        tx_chipid = 1'b1; chip_id = 8'hA7; num_payload_bits = 8'd12; wait_step = 16'd3;
        n0 = acc_total; t0 = tlast_total;
        send_word(32'hFEDC_B000, h);
        wait_idle(500, "midreset_next");
        checks++;
        if (acc_total - n0 != 108 || tlast_total - t0 != 1) begin
            errors++;
            $display("FAIL midreset_next_frame: samples=%0d tlasts=%0d required 108 1",
                     acc_total - n0, tlast_total - t0);
        end
    endtask

    initial begin
        i_tvalid = 1'b0; i_tdata = '0; tx_disable = 1'b0; tx_chipid = 1'b0; chip_id = '0;
        num_payload_bits = '0; wait_step = '0; recharge_len = '0;
        test_reset();
        test_basic();
        test_chipid_clamp();
        test_backpressure();
        test_back_to_back();
        test_tx_disable();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
